// File: rtl/sram_owner_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sram_owner_sequencer_pkg                                    |
// | Brief  : Shared state types and SRAM request record for the SRAM     |
// |          ownership sequencer.                                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sram_owner_sequencer_pkg;

    localparam logic [15:0] c_uart_timeout_default = 16'd50000;

    typedef enum logic [1:0] {
        S_OWN_IDLE    = 2'd0,
        S_OWN_UART    = 2'd1,
        S_OWN_DECODE  = 2'd2,
        S_OWN_DISPLAY = 2'd3
    } sram_owner_state_type;

    typedef struct packed {
        logic [17:0] address;
        logic [15:0] write_data;
        logic        we_n;
    } sram_req_type;

    function automatic sram_req_type sram_req_idle();
        sram_req_type r;
        r.address    = '0;
        r.write_data = '0;
        r.we_n       = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_owner_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sram_owner_sequencer                                        |
// | Brief  : Hands SRAM ownership UART -> decoder -> display with a      |
// |          registered request mux and a one-cycle handoff gap.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sram_owner_sequencer
    import sram_owner_sequencer_pkg::*;
#(
    parameter logic [15:0] UART_TIMEOUT = c_uart_timeout_default
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Load_start,
    output logic        UART_initialize,
    output logic        UART_enable,
    input  logic [17:0] UART_address,
    input  logic [15:0] UART_write_data,
    input  logic        UART_we_n,
    output logic        Dec_start,
    input  logic        Dec_done,
    input  logic [17:0] Dec_address,
    input  logic [15:0] Dec_write_data,
    input  logic        Dec_we_n,
    output logic        VGA_enable,
    input  logic [17:0] VGA_address,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [1:0]  Owner
);

    sram_owner_state_type r_state;
    sram_owner_state_type w_state_next;
    sram_req_type         r_sram;
    sram_req_type         w_uart_req;
    sram_req_type         w_dec_req;
    logic                 r_handoff;
    logic                 r_armed;
    logic [15:0]          r_idle_cnt;
    logic [16:0]          w_cnt_inc;
    logic                 w_uart_active;
    logic                 w_uart_write;
    logic                 w_timeout;
    logic                 w_state_change;

    always_comb begin
        w_uart_req     = '{address: UART_address, write_data: UART_write_data, we_n: UART_we_n};
        w_dec_req      = '{address: Dec_address, write_data: Dec_write_data, we_n: Dec_we_n};
        // The loader is only listened to once the handoff cycle is over.
        w_uart_active  = (r_state == S_OWN_UART) && !r_handoff;
        w_uart_write   = w_uart_active && !UART_we_n;
        w_cnt_inc      = {1'b0, r_idle_cnt} + 17'd1;
        w_timeout      = w_uart_active && r_armed && UART_we_n
                         && (w_cnt_inc >= {1'b0, UART_TIMEOUT});
        w_state_next   = r_state;
        case (r_state)
            S_OWN_IDLE:    if (Load_start) w_state_next = S_OWN_UART;
            S_OWN_UART:    if (w_timeout)  w_state_next = S_OWN_DECODE;
            S_OWN_DECODE:  if (Dec_done)   w_state_next = S_OWN_DISPLAY;
            S_OWN_DISPLAY: if (Load_start) w_state_next = S_OWN_UART;
            default:                       w_state_next = S_OWN_IDLE;
        endcase
        w_state_change = (w_state_next != r_state);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state         <= S_OWN_IDLE;
            r_handoff       <= 1'b0;
            r_armed         <= 1'b0;
            r_idle_cnt      <= '0;
            UART_initialize <= 1'b0;
            UART_enable     <= 1'b0;
            Dec_start       <= 1'b0;
            VGA_enable      <= 1'b0;
            r_sram          <= sram_req_idle();
        end else begin
            r_state         <= w_state_next;
            r_handoff       <= w_state_change;
            UART_initialize <= w_state_change && (w_state_next == S_OWN_UART);
            UART_enable     <= !w_state_change && (r_state == S_OWN_UART);
            Dec_start       <= w_state_change && (w_state_next == S_OWN_DECODE);
            VGA_enable      <= (w_state_next == S_OWN_DISPLAY);

            // Idle counting only starts after the first write of a load phase.
            if (w_state_change && (w_state_next == S_OWN_UART)) begin
                r_idle_cnt <= '0;
                r_armed    <= 1'b0;
            end else if (w_uart_write) begin
                r_idle_cnt <= '0;
                r_armed    <= 1'b1;
            end else if (w_uart_active && r_armed) begin
                r_idle_cnt <= (w_cnt_inc >= {1'b0, UART_TIMEOUT}) ? UART_TIMEOUT : w_cnt_inc[15:0];
            end

            // First cycle of a new owner: suppress writes, hold address/data.
            if (r_handoff) begin
                r_sram.we_n <= 1'b1;
            end else begin
                case (r_state)
                    S_OWN_UART:    r_sram <= w_uart_req;
                    S_OWN_DECODE:  r_sram <= w_dec_req;
                    S_OWN_DISPLAY: begin
                        r_sram.address <= VGA_address;
                        r_sram.we_n    <= 1'b1;
                    end
                    default:       r_sram <= sram_req_idle();
                endcase
            end
        end
    end

    assign Owner           = r_state;
    assign SRAM_address    = r_sram.address;
    assign SRAM_write_data = r_sram.write_data;
    assign SRAM_we_n       = r_sram.we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_owner_sequencer.sv
`default_nettype none
// Directed bench for sram_owner_sequencer: an edge-counting reference model
// checked every cycle, plus hand-computed expectations along the scenario.
module tb_sram_owner_sequencer;

    localparam int TO = 20;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Load_start = 1'b0;
    logic        UART_initialize, UART_enable, Dec_start, VGA_enable, SRAM_we_n;
    logic [17:0] UART_address = '0;
    logic [15:0] UART_write_data = '0;
    logic        UART_we_n = 1'b1;
    logic        Dec_done = 1'b0;
    logic [17:0] Dec_address = '0;
    logic [15:0] Dec_write_data = '0;
    logic        Dec_we_n = 1'b1;
    logic [17:0] VGA_address = '0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic [1:0]  Owner;

    int total = 0;
    int bad = 0;

    sram_owner_sequencer #(.UART_TIMEOUT(16'(TO))) dut (
        .Clock(Clock), .Resetn(Resetn), .Load_start(Load_start),
        .UART_initialize(UART_initialize), .UART_enable(UART_enable),
        .UART_address(UART_address), .UART_write_data(UART_write_data), .UART_we_n(UART_we_n),
        .Dec_start(Dec_start), .Dec_done(Dec_done),
        .Dec_address(Dec_address), .Dec_write_data(Dec_write_data), .Dec_we_n(Dec_we_n),
        .VGA_enable(VGA_enable), .VGA_address(VGA_address),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .Owner(Owner)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    // Reference model: states 0..3, time measured in clock edges.
    int          m_state = 0, m_edge = 0, m_entered = -100, m_last_wr = 0;
    bit          m_armed = 0;
    int          m_cur, m_nxt;
    bit          m_ho, m_wr, m_tmo;
    logic        e_init = 0, e_en = 0, e_start = 0, e_vga = 0, e_we_n = 1;
    logic [17:0] e_addr = '0;
    logic [15:0] e_data = '0;

    always_comb begin
        m_cur = m_edge + 1;
        m_ho  = (m_edge == m_entered);
        m_wr  = (m_state == 1) && !m_ho && (UART_we_n == 1'b0);
        m_tmo = (m_state == 1) && !m_ho && m_armed && (UART_we_n == 1'b1)
                && (m_cur - m_last_wr >= TO);
        m_nxt = m_state;
        case (m_state)
            0: if (Load_start) m_nxt = 1;
            1: if (m_tmo)      m_nxt = 2;
            2: if (Dec_done)   m_nxt = 3;
            default: if (Load_start) m_nxt = 1;
        endcase
    end

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_state <= 0; m_edge <= 0; m_entered <= -100; m_last_wr <= 0; m_armed <= 0;
            e_init <= 0; e_en <= 0; e_start <= 0; e_vga <= 0;
            e_we_n <= 1; e_addr <= '0; e_data <= '0;
        end else begin
            if (m_ho) begin
                e_we_n <= 1'b1;
            end else if (m_state == 1) begin
                e_we_n <= UART_we_n; e_addr <= UART_address; e_data <= UART_write_data;
            end else if (m_state == 2) begin
                e_we_n <= Dec_we_n; e_addr <= Dec_address; e_data <= Dec_write_data;
            end else if (m_state == 3) begin
                e_we_n <= 1'b1; e_addr <= VGA_address;
            end else begin
                e_we_n <= 1'b1; e_addr <= '0; e_data <= '0;
            end
            if (m_wr) begin
                m_last_wr <= m_cur;
                m_armed   <= 1'b1;
            end
            if (m_nxt != m_state) begin
                m_entered <= m_cur;
                if (m_nxt == 1) m_armed <= 1'b0;
            end
            e_init  <= (m_nxt == 1) && (m_state != 1);
            e_en    <= (m_nxt == 1) && (m_state == 1);
            e_start <= (m_nxt == 2) && (m_state != 2);
            e_vga   <= (m_nxt == 3);
            m_state <= m_nxt;
            m_edge  <= m_cur;
        end
    end

    always @(negedge Clock) begin
        if (Resetn === 1'b1) begin
            chk("owner", 32'(Owner), 32'(m_state));
            chk("uart_init", 32'(UART_initialize), 32'(e_init));
            chk("uart_en", 32'(UART_enable), 32'(e_en));
            chk("dec_start", 32'(Dec_start), 32'(e_start));
            chk("vga_en", 32'(VGA_enable), 32'(e_vga));
            chk("sram_we_n", 32'(SRAM_we_n), 32'(e_we_n));
            chk("sram_addr", 32'(SRAM_address), 32'(e_addr));
            chk("sram_data", 32'(SRAM_write_data), 32'(e_data));
        end
    end

    int ds_count = 0;
    int post_rst_wr = 0;
    bit watch_wr = 0;
    always @(negedge Clock) begin
        if (Dec_start === 1'b1) ds_count <= ds_count + 1;
        if (watch_wr && SRAM_we_n !== 1'b1) post_rst_wr <= post_rst_wr + 1;
    end

    initial begin
        tick(3);
        chk("rst_owner", 32'(Owner), 32'd0);
        chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("rst_addr", 32'(SRAM_address), 32'd0);
        chk("rst_data", 32'(SRAM_write_data), 32'd0);
        chk("rst_init", 32'(UART_initialize), 32'd0);
        chk("rst_en", 32'(UART_enable), 32'd0);
        chk("rst_start", 32'(Dec_start), 32'd0);
        chk("rst_vga", 32'(VGA_enable), 32'd0);
        Resetn = 1'b1;
        tick(2);
        Dec_done = 1'b1; tick(); Dec_done = 1'b0;
        chk("idle_ignores_done", 32'(Owner), 32'd0);

        Load_start = 1'b1; tick(); Load_start = 1'b0;
        chk("uart_entry_owner", 32'(Owner), 32'd1);
        chk("uart_entry_init", 32'(UART_initialize), 32'd1);
        chk("uart_entry_en", 32'(UART_enable), 32'd0);
        tick();
        chk("uart_init_1cyc", 32'(UART_initialize), 32'd0);
        chk("uart_en_level", 32'(UART_enable), 32'd1);
        tick(40);
        chk("no_timeout_before_wr", 32'(Owner), 32'd1);

        UART_address = 18'd76800; UART_write_data = 16'hABCD; UART_we_n = 1'b0; tick();
        chk("wr1_we_n", 32'(SRAM_we_n), 32'd0);
        chk("wr1_addr", 32'(SRAM_address), 32'd76800);
        chk("wr1_data", 32'(SRAM_write_data), 32'hABCD);
        UART_address = 18'd76801; UART_write_data = 16'h1234; tick();
        chk("wr2_addr", 32'(SRAM_address), 32'd76801);
        chk("wr2_data", 32'(SRAM_write_data), 32'h1234);
        UART_we_n = 1'b1;
        tick(TO - 1);
        chk("pre_expiry_owner", 32'(Owner), 32'd1);
        UART_address = 18'd76802; UART_write_data = 16'h5555; UART_we_n = 1'b0; tick();
        chk("expiry_wr_stays", 32'(Owner), 32'd1);
        chk("expiry_wr_kept", 32'(SRAM_write_data), 32'h5555);
        UART_we_n = 1'b1;
        tick(TO - 1);
        chk("restart_owner", 32'(Owner), 32'd1);
        tick();
        chk("decode_owner", 32'(Owner), 32'd2);
        chk("decode_start", 32'(Dec_start), 32'd1);
        chk("decode_en_drop", 32'(UART_enable), 32'd0);
        chk("handoff_we_n_a", 32'(SRAM_we_n), 32'd1);
        tick();
        chk("decode_start_1cyc", 32'(Dec_start), 32'd0);
        chk("handoff_we_n_b", 32'(SRAM_we_n), 32'd1);
        chk("dec_start_count", 32'(ds_count), 32'd1);

        Load_start = 1'b1; tick(); Load_start = 0;
        chk("decode_ignores_load", 32'(Owner), 32'd2);
        Dec_address = 18'h00010; Dec_write_data = 16'h7777; Dec_we_n = 1'b0; tick();
        chk("dec_wr_addr", 32'(SRAM_address), 32'h00010);
        chk("dec_wr_we_n", 32'(SRAM_we_n), 32'd0);
        Dec_address = 18'h00011; Dec_write_data = 16'h8888; Dec_done = 1'b1; tick();
        Dec_done = 1'b0;
        chk("display_owner", 32'(Owner), 32'd3);
        chk("display_vga", 32'(VGA_enable), 32'd1);
        chk("last_dec_wr_kept", 32'(SRAM_write_data), 32'h8888);
        VGA_address = 18'h00100; UART_we_n = 1'b0; tick();
        chk("disp_handoff_we_n", 32'(SRAM_we_n), 32'd1);
        chk("disp_handoff_hold", 32'(SRAM_address), 32'h00011);
        tick();
        chk("vga_addr", 32'(SRAM_address), 32'h00100);
        chk("vga_we_n", 32'(SRAM_we_n), 32'd1);
        Dec_done = 1'b1; tick(); Dec_done = 1'b0;
        chk("display_ignores_done", 32'(Owner), 32'd3);
        Dec_we_n = 1'b1; UART_we_n = 1'b1;

        Load_start = 1'b1; tick(); Load_start = 1'b0;
        chk("reload_owner", 32'(Owner), 32'd1);
        chk("reload_init", 32'(UART_initialize), 32'd1);
        tick();
        UART_address = 18'h3FFFF; UART_write_data = 16'hFFFF; UART_we_n = 1'b0; tick();
        chk("max_addr", 32'(SRAM_address), 32'h3FFFF);
        UART_we_n = 1'b1;
        tick(TO);
        chk("decode2_owner", 32'(Owner), 32'd2);
        tick();
        Dec_address = 18'h12C00; Dec_write_data = 16'hBEEF; Dec_we_n = 1'b0; tick();
        chk("pre_rst_wr", 32'(SRAM_address), 32'h12C00);
        #2 Resetn = 1'b0;
        #1;
        chk("async_we_n", 32'(SRAM_we_n), 32'd1);
        chk("async_owner", 32'(Owner), 32'd0);
        chk("async_addr", 32'(SRAM_address), 32'd0);
        tick(2);
        Resetn = 1'b1; UART_we_n = 1'b0; watch_wr = 1'b1;
        tick(10);
        watch_wr = 1'b0;
        chk("no_wr_after_rst", 32'(post_rst_wr), 32'd0);
        chk("idle_after_rst", 32'(Owner), 32'd0);
        UART_we_n = 1'b1; Dec_we_n = 1'b1;
        Load_start = 1'b1; tick(); Load_start = 1'b0;
        chk("load_after_rst", 32'(Owner), 32'd1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
